// File: rtl/oam_dma_if.sv
// CPU-side and memory-side bus bundle for the sprite DMA engine.
// cpu_rdy is the only flow control: the CPU advances on every clock where cpu_rdy=1
// and holds still while it is 0; dma_active marks the cycles in which bus_* carry DMA traffic.
interface oam_dma_if;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_d_out;
    logic        cpu_we;
    logic [7:0]  bus_din;
    logic [15:0] bus_addr;
    logic [7:0]  bus_dout;
    logic        bus_we;
    logic        cpu_rdy;
    logic        dma_active;
    logic [2:0]  dbg_state;

    modport master (
        input  cpu_addr, cpu_d_out, cpu_we, bus_din,
        output bus_addr, bus_dout, bus_we, cpu_rdy, dma_active, dbg_state
    );

    modport slave (
        output cpu_addr, cpu_d_out, cpu_we, bus_din,
        input  bus_addr, bus_dout, bus_we, cpu_rdy, dma_active, dbg_state
    );
endinterface

// File: rtl/oam_dma.sv
// NES $4014 sprite DMA: halts the CPU and copies one page to the PPU OAM port
// as alternating read/write cycles; passes the CPU bus through while idle.
module oam_dma #(
    parameter logic [15:0] DMA_REG_ADDR = 16'h4014,
    parameter logic [15:0] DEST_ADDR    = 16'h2004,
    parameter int          XFER_LEN     = 256
) (
    input  logic      clk,
    input  logic      rst,
    oam_dma_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HALT  = 3'd1,
        S_ALIGN = 3'd2,
        S_READ  = 3'd3,
        S_WRITE = 3'd4
    } state_e;

    localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

    state_e     state_q, state_d;
    logic       cyc_odd_q;
    logic [7:0] page_q, page_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] data_q, data_d;

    logic trigger;
    assign trigger = bus.cpu_we && (bus.cpu_addr == DMA_REG_ADDR);

    // State register; cyc_odd_q free-runs as the bus cycle parity reference.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cyc_odd_q <= 1'b0;
            page_q    <= 8'h00;
            idx_q     <= 8'h00;
            data_q    <= 8'h00;
        end else begin
            state_q   <= state_d;
            cyc_odd_q <= ~cyc_odd_q;
            page_q    <= page_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        idx_d   = idx_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: begin
                if (trigger) begin
                    page_d  = bus.cpu_d_out;
                    idx_d   = 8'h00;
                    state_d = S_HALT;
                end
            end
            S_HALT: begin
                // Reads must land on odd cycles, so an odd HALT needs one more dummy cycle.
                state_d = cyc_odd_q ? S_ALIGN : S_READ;
            end
            S_ALIGN: begin
                state_d = S_READ;
            end
            S_READ: begin
                data_d  = bus.bus_din;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                if (idx_q == LAST_IDX) begin
                    state_d = S_IDLE;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    state_d = S_READ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Bus outputs decoded from registered state; IDLE is a straight pass-through.
    always_comb begin
        bus.bus_addr   = bus.cpu_addr;
        bus.bus_dout   = bus.cpu_d_out;
        bus.bus_we     = bus.cpu_we;
        bus.cpu_rdy    = 1'b1;
        bus.dma_active = 1'b0;
        case (state_q)
            S_IDLE: begin
            end
            S_HALT, S_ALIGN: begin
                bus.bus_we     = 1'b0;
                bus.cpu_rdy    = 1'b0;
                bus.dma_active = 1'b1;
            end
            S_READ: begin
                bus.bus_addr   = {page_q, idx_q};
                bus.bus_we     = 1'b0;
                bus.cpu_rdy    = 1'b0;
                bus.dma_active = 1'b1;
            end
            S_WRITE: begin
                bus.bus_addr   = DEST_ADDR;
                bus.bus_dout   = data_q;
                bus.bus_we     = 1'b1;
                bus.cpu_rdy    = 1'b0;
                bus.dma_active = 1'b1;
            end
            default: begin
                bus.bus_we     = 1'b0;
                bus.cpu_rdy    = 1'b0;
                bus.dma_active = 1'b1;
            end
        endcase
    end

    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_oam_dma.sv
// Self-checking bench for oam_dma: randomized memory contents and idle traffic,
// checked cycle by cycle against a transfer model built from page/index arithmetic.
module tb_oam_dma;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic par = 1'b0;
    int   vec = 0;
    int   err = 0;

    logic [7:0] mem [65536];

    oam_dma_if bus_if ();

    oam_dma dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    assign bus_if.bus_din = mem[bus_if.bus_addr];

    always #5 clk = ~clk;

    // Bench view of cycle parity: cleared by reset, toggles every clock otherwise.
    always @(posedge clk) par <= rst ? 1'b0 : ~par;

    function automatic logic [15:0] rand_addr();
        logic [15:0] a;
        a = 16'($urandom);
        if (a == 16'h4014) a = 16'h4000;
        return a;
    endfunction

    task automatic drive_idle();
        bus_if.cpu_we    = 1'b0;
        bus_if.cpu_addr  = rand_addr();
        bus_if.cpu_d_out = 8'($urandom);
    endtask

    task automatic drive_trigger(input logic [7:0] page);
        bus_if.cpu_we    = 1'b1;
        bus_if.cpu_addr  = 16'h4014;
        bus_if.cpu_d_out = page;
    endtask

    task automatic fill_page(input logic [7:0] page);
        for (int i = 0; i < 256; i++) mem[{page, 8'(i)}] = 8'($urandom);
    endtask

    // Drive a $4014 write in a cycle chosen so the HALT cycle has the requested parity.
    task automatic trigger_with_parity(input logic [7:0] page, input bit want_halt_odd);
        bit placed;
        placed = 1'b0;
        for (int n = 0; n < 4 && !placed; n++) begin
            @(posedge clk); #1;
            if (par == !want_halt_odd) begin
                drive_trigger(page);
                placed = 1'b1;
            end else begin
                drive_idle();
            end
        end
    endtask

    task automatic trigger_now(input logic [7:0] page);
        @(posedge clk); #1;
        drive_trigger(page);
    endtask

    // Follows one transfer from its trigger cycle to the first IDLE cycle after it.
    task automatic run_xfer(input logic [7:0] page, input int retrig_at, input int abort_w,
                            input bit chain, input logic [7:0] next_page,
                            input bit at_trigger, output bit halt_odd);
        int k, p, exp_len, writes, j;
        bit done;
        logic [15:0] exp_a;
        logic [7:0]  exp_d;
        if (!at_trigger) @(negedge clk);
        vec++; if (bus_if.bus_we !== 1'b1 || bus_if.bus_addr !== 16'h4014 || bus_if.bus_dout !== page) begin
            err++; $display("FAIL trigger_passthru: got we=%b a=%h d=%h want we=1 a=4014 d=%h",
                            bus_if.bus_we, bus_if.bus_addr, bus_if.bus_dout, page);
        end
        vec++; if (bus_if.cpu_rdy !== 1'b1) begin
            err++; $display("FAIL trigger_rdy: got %b want 1", bus_if.cpu_rdy);
        end
        @(posedge clk); #1;
        drive_idle();
        k = 0; writes = 0; p = 1; exp_len = 513; halt_odd = 1'b0; done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (bus_if.cpu_rdy === 1'b1) begin
                done = 1'b1;
            end else begin
                if (k == 0) begin
                    halt_odd = par;
                    p = 1 + int'(par);
                    exp_len = 512 + p;
                end
                vec++; if (bus_if.dma_active !== 1'b1) begin
                    err++; $display("FAIL dma_active k=%0d: got %b want 1", k, bus_if.dma_active);
                end
                if (k < p) begin
                    vec++; if (bus_if.bus_we !== 1'b0 || bus_if.bus_addr !== bus_if.cpu_addr) begin
                        err++; $display("FAIL halt_bus k=%0d: got we=%b a=%h want we=0 a=%h",
                                        k, bus_if.bus_we, bus_if.bus_addr, bus_if.cpu_addr);
                    end
                end else begin
                    j = k - p;
                    if (j % 2 == 0) begin
                        exp_a = {page, 8'(j / 2)};
                        vec++; if (bus_if.bus_we !== 1'b0 || bus_if.bus_addr !== exp_a) begin
                            err++; $display("FAIL read k=%0d: got we=%b a=%h want we=0 a=%h",
                                            k, bus_if.bus_we, bus_if.bus_addr, exp_a);
                        end
                    end else begin
                        exp_d = mem[{page, 8'(j / 2)}];
                        writes++;
                        vec++; if (bus_if.bus_we !== 1'b1 || bus_if.bus_addr !== 16'h2004 || bus_if.bus_dout !== exp_d) begin
                            err++; $display("FAIL write k=%0d: got we=%b a=%h d=%h want we=1 a=2004 d=%h",
                                            k, bus_if.bus_we, bus_if.bus_addr, bus_if.bus_dout, exp_d);
                        end
                    end
                end
                k++;
                if (k >= 600) begin
                    err++; $display("FAIL xfer_timeout: got %0d busy cycles want %0d", k, exp_len);
                    done = 1'b1;
                end else begin
                    @(posedge clk); #1;
                    if (rst) begin
                        rst = 1'b0;
                        bus_if.cpu_we = 1'b1; bus_if.cpu_addr = 16'h0010; bus_if.cpu_d_out = 8'h3C;
                    end else if (abort_w > 0 && k == p + 2 * abort_w - 1) begin
                        rst = 1'b1;
                        drive_idle();
                    end else if (chain && k == exp_len) begin
                        drive_trigger(next_page);
                    end else if (k == retrig_at) begin
                        drive_trigger(8'h07);
                    end else begin
                        drive_idle();
                    end
                end
            end
        end
        vec++; if (bus_if.dma_active !== 1'b0) begin
            err++; $display("FAIL end_active: got %b want 0", bus_if.dma_active);
        end
        if (abort_w > 0) begin
            vec++; if (writes != abort_w) begin
                err++; $display("FAIL abort_writes: got %0d want %0d", writes, abort_w);
            end
            vec++; if (bus_if.bus_we !== 1'b1 || bus_if.bus_addr !== 16'h0010 || bus_if.bus_dout !== 8'h3C) begin
                err++; $display("FAIL abort_passthru: got we=%b a=%h d=%h want we=1 a=0010 d=3c",
                                bus_if.bus_we, bus_if.bus_addr, bus_if.bus_dout);
            end
        end else begin
            vec++; if (k != exp_len) begin
                err++; $display("FAIL busy_len: got %0d want %0d", k, exp_len);
            end
            vec++; if (writes != 256) begin
                err++; $display("FAIL write_count: got %0d want 256", writes);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus_if.cpu_we = 1'($urandom);
            bus_if.cpu_addr = rand_addr();
            bus_if.cpu_d_out = 8'($urandom);
            @(negedge clk);
            vec++; if (bus_if.cpu_rdy !== 1'b1 || bus_if.dma_active !== 1'b0) begin
                err++; $display("FAIL reset_ctrl: got rdy=%b act=%b want rdy=1 act=0",
                                bus_if.cpu_rdy, bus_if.dma_active);
            end
            vec++; if (bus_if.bus_we !== bus_if.cpu_we || bus_if.bus_addr !== bus_if.cpu_addr || bus_if.bus_dout !== bus_if.cpu_d_out) begin
                err++; $display("FAIL reset_passthru: got we=%b a=%h d=%h want we=%b a=%h d=%h",
                                bus_if.bus_we, bus_if.bus_addr, bus_if.bus_dout,
                                bus_if.cpu_we, bus_if.cpu_addr, bus_if.cpu_d_out);
            end
            @(posedge clk); #1;
        end
        drive_idle();
    endtask

    task automatic test_passthrough();
        logic [15:0] addrs [3];
        addrs[0] = 16'h0010; addrs[1] = 16'h4015; addrs[2] = 16'h4013;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            bus_if.cpu_we = 1'b1; bus_if.cpu_addr = addrs[i]; bus_if.cpu_d_out = 8'h3C;
            @(negedge clk);
            vec++; if (bus_if.bus_we !== 1'b1 || bus_if.bus_addr !== addrs[i] || bus_if.bus_dout !== 8'h3C) begin
                err++; $display("FAIL passthru %h: got we=%b a=%h d=%h want we=1 a=%h d=3c",
                                addrs[i], bus_if.bus_we, bus_if.bus_addr, bus_if.bus_dout, addrs[i]);
            end
            @(posedge clk); #1;
            drive_idle();
            @(negedge clk);
            vec++; if (bus_if.cpu_rdy !== 1'b1 || bus_if.dma_active !== 1'b0) begin
                err++; $display("FAIL no_trigger %h: got rdy=%b act=%b want rdy=1 act=0",
                                addrs[i], bus_if.cpu_rdy, bus_if.dma_active);
            end
        end
    endtask

    task automatic test_even_start();
        bit ho;
        for (int i = 0; i < 256; i++) mem[16'h0200 + 16'(i)] = 8'(i) ^ 8'hA5;
        trigger_with_parity(8'h02, 1'b0);
        run_xfer(8'h02, -1, 0, 1'b0, 8'h00, 1'b0, ho);
        vec++; if (ho !== 1'b0) begin
            err++; $display("FAIL even_halt_parity: got %b want 0", ho);
        end
    endtask

    task automatic test_odd_start();
        bit ho;
        trigger_with_parity(8'h02, 1'b1);
        run_xfer(8'h02, -1, 0, 1'b0, 8'h00, 1'b0, ho);
        vec++; if (ho !== 1'b1) begin
            err++; $display("FAIL odd_halt_parity: got %b want 1", ho);
        end
    endtask

    task automatic test_retrigger();
        bit ho;
        fill_page(8'h05);
        for (int i = 0; i < 256; i++) mem[{8'h07, 8'(i)}] = ~mem[{8'h05, 8'(i)}];
        trigger_now(8'h05);
        run_xfer(8'h05, int'($urandom_range(1, 500)), 0, 1'b0, 8'h00, 1'b0, ho);
    endtask

    task automatic test_back_to_back();
        bit ho;
        fill_page(8'h03);
        fill_page(8'hFF);
        trigger_now(8'h03);
        run_xfer(8'h03, -1, 0, 1'b1, 8'hFF, 1'b0, ho);
        run_xfer(8'hFF, -1, 0, 1'b0, 8'h00, 1'b1, ho);
    endtask

    task automatic test_reset_mid();
        bit ho;
        fill_page(8'h04);
        trigger_now(8'h04);
        run_xfer(8'h04, -1, 100, 1'b0, 8'h00, 1'b0, ho);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            drive_idle();
            @(negedge clk);
            vec++; if (bus_if.dma_active !== 1'b0 || bus_if.cpu_rdy !== 1'b1 || bus_if.bus_we !== 1'b0) begin
                err++; $display("FAIL post_reset_idle: got act=%b rdy=%b we=%b want 0 1 0",
                                bus_if.dma_active, bus_if.cpu_rdy, bus_if.bus_we);
            end
        end
    endtask

    task automatic test_random_xfers();
        bit ho;
        logic [7:0] pg;
        for (int n = 0; n < 3; n++) begin
            pg = 8'($urandom);
            fill_page(pg);
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
                drive_idle();
            end
            trigger_with_parity(pg, 1'($urandom));
            run_xfer(pg, -1, 0, 1'b0, 8'h00, 1'b0, ho);
        end
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_passthrough();
        test_even_start();
        test_odd_start();
        test_retrigger();
        test_back_to_back();
        test_reset_mid();
        test_random_xfers();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/oam_dma.md
Name: oam_dma

Overview:
- CPU-bus master for the NES sprite DMA register ($4014).
- Sits directly downstream of the cpu core on its address/data/write bus.
- A CPU write to $4014 halts the CPU and copies one 256-byte page ({page, 8'h00}..{page, 8'hFF}) to the PPU OAM data port ($2004) as alternating read/write cycles.
- While idle, it passes the CPU bus through unchanged to memory/PPU decode.

Parameters:
- DMA_REG_ADDR, 16'h4014, CPU write address that triggers DMA.
- DEST_ADDR, 16'h2004, fixed write target for every transferred byte.
- XFER_LEN, 256, bytes per transfer (legal 1..256); source low byte runs 0..XFER_LEN-1.

Ports:
- clk  in  1  system clock, one CPU cycle per clock
- rst  in  1  synchronous, active-high reset
- cpu_addr  in  16  CPU address
- cpu_d_out  in  8  CPU write data
- cpu_we  in  1  CPU write strobe, high for the cycle of the write
- bus_din  in  8  read data from memory; valid combinationally in the same cycle as bus_addr
- bus_addr  out  16  muxed bus address
- bus_dout  out  8  muxed bus write data
- bus_we  out  1  muxed bus write strobe
- cpu_rdy  out  1  high = CPU may advance; low = CPU halted
- dma_active  out  1  high while DMA owns the bus

Behaviour:
- Reset:
  - state=IDLE, cyc_odd=0, page=0, idx=0, data latch=0.
  - cpu_rdy=1, dma_active=0; bus outputs pass CPU through.
- cyc_odd: toggles every clock after reset (0,1,0,...); it is the cycle-parity reference.
- Trigger: in IDLE, a rising clk edge with cpu_we=1 and cpu_addr==DMA_REG_ADDR:
  - latches page<=cpu_d_out and idx<=0;
  - moves to HALT.
  - The trigger write itself still passes through to the bus.
- States:
  - IDLE: bus_addr=cpu_addr, bus_dout=cpu_d_out, bus_we=cpu_we, cpu_rdy=1, dma_active=0.
  - HALT: one dummy cycle; bus_we=0, bus_addr=cpu_addr. If cyc_odd==1 during HALT -> ALIGN, else -> READ.
  - ALIGN: one extra dummy cycle, same outputs as HALT; -> READ.
  - READ: bus_addr={page, idx}, bus_we=0; bus_din captured into the data latch at the end of the cycle; -> WRITE. READ always falls on cyc_odd==1.
  - WRITE: bus_addr=DEST_ADDR, bus_dout=latch, bus_we=1. If idx==XFER_LEN-1 -> IDLE, else idx<=idx+1 and -> READ.
- In every non-IDLE state: cpu_rdy=0, dma_active=1. Outputs are decoded from registered state only.
- Latency:
  - 513 non-IDLE cycles when the trigger edge leaves cyc_odd=0 in HALT.
  - 514 non-IDLE cycles when HALT has cyc_odd=1.
  - cpu_rdy returns to 1 in the cycle after the last WRITE.
- Boundaries:
  - idx is 8 bits; XFER_LEN=256 ends at idx=8'hFF with no wrap into the next page.
  - Page 8'hFF reads up to 16'hFFFF.
- Simultaneous events:
  - CPU writes to DMA_REG_ADDR while not IDLE are ignored; the CPU is halted, but the bench may force them.
  - A trigger is accepted in the first IDLE cycle after completion, giving back-to-back transfers.
- Writes to other addresses never trigger, including 16'h4015 and 16'h4013.
- Reset mid-transfer: the next cycle is IDLE with all reset values; no further bus_we from the DMA; the partial transfer is abandoned.

Test Plan:
- Even start: memory[16'h0200+i]=i^8'hA5, write 8'h02 to $4014 with HALT on cyc_odd=0 -> exactly 513 cycles cpu_rdy=0; 256 writes to 16'h2004 with data i^8'hA5 in order; READ addresses 16'h0200..16'h02FF.
- Odd start: same transfer triggered one cycle later -> 514 cycles low; first READ on cyc_odd=1; identical data sequence.
- Pass-through: CPU write 8'h3C to 16'h0010 and to 16'h4015 while idle -> bus mirrors CPU the same cycle; no DMA start; cpu_rdy stays 1.
- Reset mid-op: assert rst during the 100th WRITE -> next cycle cpu_rdy=1, dma_active=0, bus_we follows cpu_we; exactly 99 or 100 DMA writes seen, none after reset.
- Back-to-back: trigger page 8'h03, then page 8'hFF the first cycle after completion -> second transfer reads 16'hFF00..16'hFFFF; no stray write between transfers.
- Forced re-trigger: drive a $4014 write with 8'h07 mid-transfer -> ignored; page stays at its original value.
